// File: rtl/bp_coherence_network_chunk_serializer.sv
// bp_coherence_network_chunk_serializer
//
// Per-source serializer for the coherence network. Accepts one wide packet,
// splits it into chunk_width_p flits and emits each flit with a
// {dst, src, last} header. The chunk order is set by msb_first_p.
//
// Optional feature: define BP_CHUNK_SERIALIZER_PARITY_EN to prepend an even
// parity bit, ^{dst, src, last, chunk}, as the MSB of every flit.
//
// Ports
//   clk_i    in   1               clock
//   reset_i  in   1               synchronous, active-high reset
//   data_i   in   packet_width_p  packet to serialize
//   v_i      in   1               packet valid (captured only while ready_o=1)
//   ready_o  out  1               serializer can accept a packet this cycle
//   data_o   out  flit_width_lp   {[parity], dst, src, last, chunk}
//   v_o      out  1               flit valid
//   yumi_i   in   1               flit consumed (only meaningful while v_o=1)
//
// state | meaning
// ------+-----------------------------------------------------------
// idle  | waiting for a packet; ready_o=1 (except during reset)
// send  | presenting chunk[idx(count)]; advances on yumi_i
module bp_coherence_network_chunk_serializer #(
    parameter int packet_width_p = 20,
    parameter int chunk_width_p  = 8,
    parameter int num_src_p      = 4,
    parameter int num_dst_p      = 4,
    parameter int src_id_p       = 0,
    parameter int dst_id_lsb_p   = 0,
    parameter int msb_first_p    = 0,
    localparam int num_chunks_lp = (packet_width_p + chunk_width_p - 1) / chunk_width_p,
    localparam int src_w_lp      = (num_src_p <= 1) ? 1 : $clog2(num_src_p),
    localparam int dst_w_lp      = (num_dst_p <= 1) ? 1 : $clog2(num_dst_p),
`ifdef BP_CHUNK_SERIALIZER_PARITY_EN
    localparam int parity_w_lp   = 1,
`else
    localparam int parity_w_lp   = 0,
`endif
    localparam int flit_width_lp = parity_w_lp + dst_w_lp + src_w_lp + 1 + chunk_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [packet_width_p-1:0] data_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [flit_width_lp-1:0]  data_o,
    output logic                      v_o,
    input  logic                      yumi_i
);

    localparam int cnt_w_lp    = (num_chunks_lp <= 1) ? 1 : $clog2(num_chunks_lp);
    localparam int padded_w_lp = num_chunks_lp * chunk_width_p;
    localparam int body_w_lp   = dst_w_lp + src_w_lp + 1 + chunk_width_p;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(num_chunks_lp - 1);

    typedef enum logic {
        st_idle,
        st_send
    } state_e;

    state_e                   state_r, state_n;
    logic [cnt_w_lp-1:0]      count_r, count_n;
    logic [padded_w_lp-1:0]   packet_r;
    logic [dst_w_lp-1:0]      dst_r;
    logic                     capture;
    logic                     last;
    logic [cnt_w_lp-1:0]      idx;
    logic [chunk_width_p-1:0] chunk;
    logic [body_w_lp-1:0]     body;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= st_idle;
            count_r <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
        end
    end

    // Datapath registers carry no reset: their contents only matter once
    // a capture has taken place.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            packet_r <= padded_w_lp'(data_i);
            dst_r    <= data_i[dst_id_lsb_p +: dst_w_lp];
        end
    end

    assign last = (count_r == last_cnt_lp);

    always_comb begin
        state_n = state_r;
        count_n = count_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        capture = 1'b0;
        case (state_r)
            st_idle: begin
                // Held low during reset so nothing is accepted that the reset discards.
                ready_o = !reset_i;
                if (v_i && !reset_i) begin
                    capture = 1'b1;
                    count_n = '0;
                    state_n = st_send;
                end
            end
            st_send: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    if (last) begin
                        count_n = '0;
                        state_n = st_idle;
                    end else begin
                        count_n = count_r + cnt_w_lp'(1);
                    end
                end
            end
            default: begin
                state_n = st_idle;
                count_n = '0;
            end
        endcase
    end

    assign idx = (msb_first_p != 0) ? (last_cnt_lp - count_r) : count_r;

    always_comb begin
        chunk = '0;
        for (int i = 0; i < num_chunks_lp; i++) begin
            if (idx == cnt_w_lp'(i)) chunk = packet_r[i*chunk_width_p +: chunk_width_p];
        end
    end

    assign body = {dst_r, src_w_lp'(src_id_p), last, chunk};

`ifdef BP_CHUNK_SERIALIZER_PARITY_EN
    assign data_o = {^body, body};
`else
    assign data_o = body;
`endif

endmodule

// File: tb/tb_bp_coherence_network_chunk_serializer.sv
module tb_bp_coherence_network_chunk_serializer;

`ifdef BP_CHUNK_SERIALIZER_PARITY_EN
    localparam int FW = 14;
`else
    localparam int FW = 13;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic          yumi_i = 1'b0;
    logic [19:0]   data_i = '0;
    logic          ready_l, v_l, ready_m, v_m;
    logic [FW-1:0] data_l, data_m;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bp_coherence_network_chunk_serializer #(
        .packet_width_p(20), .chunk_width_p(8), .num_src_p(4), .num_dst_p(4),
        .src_id_p(2), .dst_id_lsb_p(0), .msb_first_p(0)
    ) dut_lsb (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
        .ready_o(ready_l), .data_o(data_l), .v_o(v_l), .yumi_i(yumi_i)
    );

    bp_coherence_network_chunk_serializer #(
        .packet_width_p(20), .chunk_width_p(8), .num_src_p(4), .num_dst_p(4),
        .src_id_p(2), .dst_id_lsb_p(0), .msb_first_p(1)
    ) dut_msb (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
        .ready_o(ready_m), .data_o(data_m), .v_o(v_m), .yumi_i(yumi_i)
    );

    // Expected flit for this bench's source id (2'b10).
    function automatic logic [FW-1:0] exp_flit(input logic [1:0] dst, input logic last,
                                               input logic [7:0] ch);
        logic [12:0] b;
        b = {dst, 2'b10, last, ch};
`ifdef BP_CHUNK_SERIALIZER_PARITY_EN
        return {^b, b};
`else
        return b;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        total++; if (ready_l !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ready_l); else passed++;
        total++; if (v_l !== 1'b0)     $display("FAIL reset_v got=%0b exp=0", v_l); else passed++;
        total++; if (v_m !== 1'b0)     $display("FAIL reset_v_msb got=%0b exp=0", v_m); else passed++;
        step();
        reset_i = 1'b0;
        #1;
        total++; if (ready_l !== 1'b1) $display("FAIL post_reset_ready got=%0b exp=1", ready_l); else passed++;
    endtask

    task automatic test_lsb_msb();
        logic [7:0] lsb_ch [3];
        logic [7:0] msb_ch [3];
        lsb_ch = '{8'hDE, 8'hBC, 8'h0A};
        msb_ch = '{8'h0A, 8'hBC, 8'hDE};
        data_i = 20'hABCDE; v_i = 1'b1; yumi_i = 1'b1;
        step();
        v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (v_l !== 1'b1) $display("FAIL lsb_v%0d got=%0b exp=1", i, v_l); else passed++;
            total++; if (data_l !== exp_flit(2'b10, (i == 2), lsb_ch[i]))
                $display("FAIL lsb_flit%0d got=%h exp=%h", i, data_l, exp_flit(2'b10, (i == 2), lsb_ch[i]));
            else passed++;
            total++; if (data_m !== exp_flit(2'b10, (i == 2), msb_ch[i]))
                $display("FAIL msb_flit%0d got=%h exp=%h", i, data_m, exp_flit(2'b10, (i == 2), msb_ch[i]));
            else passed++;
`ifdef BP_CHUNK_SERIALIZER_PARITY_EN
            if (i == 0) begin
                total++; if (data_l[FW-1] !== 1'b0) $display("FAIL parity_DE got=%0b exp=0", data_l[FW-1]); else passed++;
            end
            if (i == 2) begin
                total++; if (data_l[FW-1] !== 1'b1) $display("FAIL parity_0A got=%0b exp=1", data_l[FW-1]); else passed++;
            end
`endif
            step();
        end
        total++; if (ready_l !== 1'b1) $display("FAIL lsb_done_ready got=%0b exp=1", ready_l); else passed++;
        total++; if (v_l !== 1'b0)     $display("FAIL lsb_done_v got=%0b exp=0", v_l); else passed++;
        total++; if (ready_m !== 1'b1) $display("FAIL msb_done_ready got=%0b exp=1", ready_m); else passed++;
        total++; if (v_m !== 1'b0)     $display("FAIL msb_done_v got=%0b exp=0", v_m); else passed++;
        yumi_i = 1'b0;
    endtask

    task automatic test_backpressure();
        data_i = 20'hABCDE; v_i = 1'b1; yumi_i = 1'b1;
        step();
        v_i = 1'b0;
        step();
        yumi_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (v_l !== 1'b1) $display("FAIL bp_v%0d got=%0b exp=1", i, v_l); else passed++;
            total++; if (data_l !== exp_flit(2'b10, 1'b0, 8'hBC))
                $display("FAIL bp_hold%0d got=%h exp=%h", i, data_l, exp_flit(2'b10, 1'b0, 8'hBC));
            else passed++;
        end
        yumi_i = 1'b1;
        step();
        total++; if (data_l !== exp_flit(2'b10, 1'b1, 8'h0A))
            $display("FAIL bp_last got=%h exp=%h", data_l, exp_flit(2'b10, 1'b1, 8'h0A));
        else passed++;
        step();
        yumi_i = 1'b0;
        total++; if (ready_l !== 1'b1) $display("FAIL bp_done_ready got=%0b exp=1", ready_l); else passed++;
    endtask

    task automatic test_ignored_inputs();
        yumi_i = 1'b1;
        step();
        step();
        total++; if (v_l !== 1'b0)     $display("FAIL idle_yumi_v got=%0b exp=0", v_l); else passed++;
        total++; if (ready_l !== 1'b1) $display("FAIL idle_yumi_ready got=%0b exp=1", ready_l); else passed++;
        yumi_i = 1'b0;
        data_i = 20'h12345; v_i = 1'b1;
        step();
        data_i = 20'hFFFFF;
        step();
        step();
        total++; if (ready_l !== 1'b0) $display("FAIL send_ready got=%0b exp=0", ready_l); else passed++;
        total++; if (data_l !== exp_flit(2'b01, 1'b0, 8'h45))
            $display("FAIL send_vi_ignored got=%h exp=%h", data_l, exp_flit(2'b01, 1'b0, 8'h45));
        else passed++;
        v_i = 1'b0; yumi_i = 1'b1;
        step();
        total++; if (data_l !== exp_flit(2'b01, 1'b0, 8'h23))
            $display("FAIL ign_flit1 got=%h exp=%h", data_l, exp_flit(2'b01, 1'b0, 8'h23));
        else passed++;
        step();
        total++; if (data_l !== exp_flit(2'b01, 1'b1, 8'h01))
            $display("FAIL ign_flit2 got=%h exp=%h", data_l, exp_flit(2'b01, 1'b1, 8'h01));
        else passed++;
        step();
        yumi_i = 1'b0;
        step();
        total++; if (v_l !== 1'b0) $display("FAIL no_extra_capture got=%0b exp=0", v_l); else passed++;
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] ch [3];
        ch = '{8'h01, 8'h00, 8'h00};
        data_i = 20'hABCDE; v_i = 1'b1; yumi_i = 1'b1;
        step();
        v_i = 1'b0;
        step();
        yumi_i = 1'b0;
        reset_i = 1'b1;
        step();
        total++; if (v_l !== 1'b0)     $display("FAIL midrst_v got=%0b exp=0", v_l); else passed++;
        total++; if (ready_l !== 1'b0) $display("FAIL midrst_ready got=%0b exp=0", ready_l); else passed++;
        reset_i = 1'b0;
        #1;
        total++; if (ready_l !== 1'b1) $display("FAIL midrst_release_ready got=%0b exp=1", ready_l); else passed++;
        data_i = 20'h00001; v_i = 1'b1; yumi_i = 1'b1;
        step();
        v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (data_l !== exp_flit(2'b01, (i == 2), ch[i]))
                $display("FAIL midrst_flit%0d got=%h exp=%h", i, data_l, exp_flit(2'b01, (i == 2), ch[i]));
            else passed++;
            step();
        end
        yumi_i = 1'b0;
        total++; if (v_l !== 1'b0) $display("FAIL midrst_done_v got=%0b exp=0", v_l); else passed++;
    endtask

    initial begin
        test_reset();
        test_lsb_msb();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
